mgt_01_int_divider: RTL and testbench

MGT_01_INT_DIVIDER -- requirements
Module: mgt_01_int_divider

---
 rtl/mgt_01_int_divider_pkg.sv | 13 +
 rtl/mgt_01_int_divider.sv | 165 ++++++++++++++++
 tb/tb_mgt_01_int_divider.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mgt_01_int_divider_pkg.sv
// Shared definitions for the iterative integer divider: operand width and operation encoding.
package mgt_01_int_divider_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

endpackage

// File: rtl/mgt_01_int_divider.sv
// Radix-2 non-restoring integer divider (DIV/DIVU/REM/REMU), one quotient bit per enabled cycle.
// Divide-by-zero and signed overflow bypass the iteration and report on the next edge.
module mgt_01_int_divider #(
  parameter int unsigned XLEN = mgt_01_int_divider_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            clk_en_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            kill_i,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o,
  output logic            busy_o,
  output logic            div_zero_o
);
  import mgt_01_int_divider_pkg::*;

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StDivide, StRestore, StValid} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              is_rem_q, is_rem_d;
  logic              dz_pend_q, dz_pend_d;
  logic              valid_q, valid_d;
  logic              dz_q, dz_d;

  div_op_e           op;
  logic              op_signed, op_rem, a_neg, b_neg, overflow;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     shifted, step;
  logic [XLEN-1:0]   rem_fix, quo_out, rem_out;

  assign op        = div_op_e'(op_i);
  assign op_signed = (op == DIV) || (op == REM);
  assign op_rem    = (op == REM) || (op == REMU);
  assign a_neg     = op_signed & dividend_i[XLEN-1];
  assign b_neg     = op_signed & divisor_i[XLEN-1];
  assign abs_a     = a_neg ? (~dividend_i + 1'b1) : dividend_i;
  assign abs_b     = b_neg ? (~divisor_i + 1'b1) : divisor_i;
  assign overflow  = op_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (&divisor_i);

  // Partial remainder stays in [-D, D); the dropped top bit of the shift cancels modulo 2^(XLEN+1).
  assign shifted = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign step    = rem_q[XLEN] ? (shifted + {1'b0, dvs_q}) : (shifted - {1'b0, dvs_q});

  assign rem_fix = rem_q[XLEN] ? (rem_q[XLEN-1:0] + dvs_q) : rem_q[XLEN-1:0];
  assign quo_out = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_out = neg_rem_q ? (~rem_fix + 1'b1) : rem_fix;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    res_d     = res_q;
    result_d  = result_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    dz_pend_d = dz_pend_q;
    valid_d   = valid_q;
    dz_d      = dz_q;
    if (clk_en_i) begin
      valid_d = 1'b0;
      dz_d    = 1'b0;
      if (kill_i) begin
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              is_rem_d = op_rem;
              if (divisor_i == '0) begin
                res_d     = op_rem ? dividend_i : '1;
                dz_pend_d = 1'b1;
                state_d   = StValid;
              end else if (overflow) begin
                res_d     = op_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                dz_pend_d = 1'b0;
                state_d   = StValid;
              end else begin
                rem_d     = '0;
                quo_d     = abs_a;
                dvs_d     = abs_b;
                cnt_d     = '0;
                neg_quo_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                dz_pend_d = 1'b0;
                state_d   = StDivide;
              end
            end
          end
          StDivide: begin
            rem_d = step;
            quo_d = {quo_q[XLEN-2:0], ~step[XLEN]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = StRestore;
          end
          StRestore: begin
            res_d   = is_rem_q ? rem_out : quo_out;
            state_d = StValid;
          end
          StValid: begin
            result_d = res_q;
            valid_d  = 1'b1;
            dz_d     = dz_pend_q;
            state_d  = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      dz_pend_q <= 1'b0;
      valid_q   <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      res_q     <= res_d;
      result_q  <= result_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      dz_pend_q <= dz_pend_d;
      valid_q   <= valid_d;
      dz_q      <= dz_d;
    end
  end

  assign result_o   = result_q;
  assign valid_o    = valid_q;
  assign busy_o     = (state_q != StIdle);
  assign div_zero_o = dz_q;

endmodule

// File: tb/tb_mgt_01_int_divider.sv
// Self-checking bench for mgt_01_int_divider: directed vectors, kill/stall/reset cases and
// randomized operations scored against a plain-arithmetic reference model.
module tb_mgt_01_int_divider;
  import mgt_01_int_divider_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        clk_en_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        kill_i;
  logic [31:0] result_o;
  logic        valid_o;
  logic        busy_o;
  logic        div_zero_o;

  int n_checks = 0;
  int n_errors = 0;

  mgt_01_int_divider #(.XLEN(32)) u_dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clk_en_i   (clk_en_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .kill_i     (kill_i),
    .result_o   (result_o),
    .valid_o    (valid_o),
    .busy_o     (busy_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit arithmetic, so signed overflow and truncation fall out naturally.
  function automatic void ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic dz);
    longint sa, sb, q, r;
    logic   sgn;
    sgn = (op == DIV) || (op == REM);
    dz  = (b == 32'd0);
    if (dz) begin
      q = -1;
      r = longint'({32'd0, a});
    end else begin
      sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      q  = sa / sb;
      r  = sa % sb;
    end
    res = op[1] ? r[31:0] : q[31:0];
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall_at, input int stall_len, input bit poke_start,
                        input bit hold_valid);
    logic [31:0] exp_res;
    logic        exp_dz;
    int          exp_lat;
    int          n;
    bit          seen;
    bit          special;
    ref_div(op, a, b, exp_res, exp_dz);
    special = (b == 32'd0) ||
              (((op == DIV) || (op == REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    exp_lat = special ? 1 : 34 + ((stall_at < 34) ? stall_len : 0);
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; clk_en_i = 1'b1;
    @(posedge clk_i); #1;
    check_eq("busy_after_start", {31'd0, busy_o}, 32'd1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk_i);
      start_i  = poke_start && (n == 5);
      if (start_i) begin
        dividend_i = $urandom;
        divisor_i  = $urandom_range(1, 50);
      end
      clk_en_i = !(n >= stall_at && n < stall_at + stall_len);
      @(posedge clk_i); #1;
      n++;
      if (valid_o) seen = 1'b1;
    end
    start_i  = 1'b0;
    clk_en_i = 1'b1;
    check_eq("latency", n, exp_lat);
    check_eq("result", result_o, exp_res);
    check_eq("div_zero", {31'd0, div_zero_o}, {31'd0, exp_dz});
    if (hold_valid) begin
      @(negedge clk_i); clk_en_i = 1'b0;
      @(posedge clk_i); #1;
      check_eq("valid_frozen", {31'd0, valid_o}, 32'd1);
      @(negedge clk_i); clk_en_i = 1'b1;
    end
    @(posedge clk_i); #1;
    check_eq("valid_pulse", {31'd0, valid_o}, 32'd0);
    check_eq("result_hold", result_o, exp_res);
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] a, b;
    logic [1:0]  op;
    int          vcount;

    rst_n_i = 1'b0; clk_en_i = 1'b1; start_i = 1'b0; kill_i = 1'b0;
    op_i = 2'd0; dividend_i = '0; divisor_i = '0;
    #1;
    check_eq("reset_state", {result_o[31:3], valid_o, busy_o, div_zero_o}, 32'd0);
    #20;
    @(negedge clk_i); rst_n_i = 1'b1;

    run_op(DIVU, 32'd100, 32'd7, 100, 0, 1'b0, 1'b0);
    run_op(REMU, 32'd100, 32'd7, 100, 0, 1'b0, 1'b0);
    run_op(DIV,  32'hFFFF_FFF9, 32'd2, 100, 0, 1'b0, 1'b0);
    run_op(REM,  32'hFFFF_FFF9, 32'd2, 100, 0, 1'b0, 1'b0);
    run_op(DIVU, 32'h1234, 32'd0, 100, 0, 1'b0, 1'b0);
    run_op(REMU, 32'h1234, 32'd0, 100, 0, 1'b0, 1'b0);
    run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 100, 0, 1'b0, 1'b0);
    run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 100, 0, 1'b0, 1'b0);
    run_op(DIVU, 32'hFFFF_FFFF, 32'd1, 10, 5, 1'b0, 1'b0);
    run_op(DIV,  32'd1000, 32'hFFFF_FFF6, 100, 0, 1'b1, 1'b1);

    // Kill at iteration 10: back to idle, no result, previous result retained.
    prev = result_o;
    @(negedge clk_i);
    start_i = 1'b1; op_i = DIVU; dividend_i = 32'd5000; divisor_i = 32'd3;
    @(posedge clk_i);
    @(negedge clk_i); start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    @(negedge clk_i); kill_i = 1'b1;
    @(posedge clk_i); #1;
    check_eq("kill_idle", {31'd0, busy_o}, 32'd0);
    check_eq("kill_result", result_o, prev);
    @(negedge clk_i); kill_i = 1'b0;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (valid_o) vcount++;
    end
    check_eq("kill_no_valid", vcount, 0);
    run_op(DIVU, 32'd9, 32'd3, 100, 0, 1'b0, 1'b0);

    // Kill beats start in idle.
    @(negedge clk_i);
    start_i = 1'b1; kill_i = 1'b1; op_i = DIVU; dividend_i = 32'd8; divisor_i = 32'd2;
    @(posedge clk_i); #1;
    check_eq("kill_over_start", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i); start_i = 1'b0; kill_i = 1'b0;

    // Asynchronous reset mid-divide clears outputs without a clock edge.
    @(negedge clk_i);
    start_i = 1'b1; op_i = DIV; dividend_i = 32'hFFFF_0000; divisor_i = 32'd0;
    @(posedge clk_i);
    @(negedge clk_i); start_i = 1'b0;
    @(posedge clk_i); #1;
    check_eq("pre_reset_result", result_o, 32'hFFFF_FFFF);
    @(negedge clk_i);
    start_i = 1'b1; op_i = DIVU; dividend_i = 32'd77; divisor_i = 32'd5;
    @(posedge clk_i);
    @(negedge clk_i); start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #2; rst_n_i = 1'b0;
    #1;
    check_eq("reset_mid_result", result_o, 32'd0);
    check_eq("reset_mid_flags", {29'd0, valid_o, busy_o, div_zero_o}, 32'd0);
    @(negedge clk_i); rst_n_i = 1'b1;
    run_op(REMU, 32'd77, 32'd5, 100, 0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: begin a = $urandom_range(0, 200); b = $urandom_range(1, 300); end
        4: b = -$urandom_range(1, 15);
        default: ;
      endcase
      run_op(op, a, b, 100, 0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
